serial_out_arbiter: RTL and testbench

SERIAL_OUT_ARBITER -- requirements
Module: serial_out_arbiter

---
 rtl/serial_out_arbiter.sv | 119 +++++++++++
 tb/tb_serial_out_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/serial_out_arbiter.sv
// Merges several idle-high serial sources onto one TX line, granting the lowest-index edging channel.
// Optional ownership lock with hold timer when SOUT_LOCK_EN is defined; otherwise last-changed-wins.
module serial_out_arbiter #(
   parameter int CHANNELS    = 3,
   parameter int LOCK_CYCLES = 840000,
   localparam int OWNER_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk_sys,
   input  logic                reset,
   input  logic [CHANNELS-1:0] ch_in,
   input  logic [CHANNELS-1:0] ch_en,
   output logic                tx_out,
   output logic [OWNER_W-1:0]  owner,
   output logic                owner_valid,
   output logic                collision
);

   if (CHANNELS < 2 || CHANNELS > 8) begin : g_bad_channels
      $error("serial_out_arbiter: CHANNELS out of range");
   end
   if (LOCK_CYCLES < 1 || LOCK_CYCLES > 16777215) begin : g_bad_lock
      $error("serial_out_arbiter: LOCK_CYCLES out of range");
   end

   logic [CHANNELS-1:0] prev_p0;
   logic [CHANNELS-1:0] ch_edge;
   logic [OWNER_W-1:0]  win_idx;
   logic                any_edge;
   logic                multi_edge;

   assign ch_edge    = (ch_in ^ prev_p0) & ch_en;
   assign multi_edge = |(ch_edge & (ch_edge - CHANNELS'(1)));

   always_comb begin
      win_idx  = '0;
      any_edge = 1'b0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (ch_edge[i]) begin
            win_idx  = OWNER_W'(i);
            any_edge = 1'b1;
         end
      end
   end

`ifdef SOUT_LOCK_EN
   localparam int                CNT_W      = $clog2(LOCK_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(LOCK_CYCLES - 1);
   localparam logic [0:0]        S_IDLE     = 1'b0;
   localparam logic [0:0]        S_LOCKED   = 1'b1;

   logic [0:0]          state;
   logic [CNT_W-1:0]    lock_cnt;
   logic [CHANNELS-1:0] other_edges;

   assign other_edges = ch_edge & ~(CHANNELS'(1) << owner);

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         prev_p0     <= '1;
         tx_out      <= 1'b1;
         owner       <= '0;
         owner_valid <= 1'b0;
         collision   <= 1'b0;
         state       <= S_IDLE;
         lock_cnt    <= '0;
      end else begin
         prev_p0 <= ch_in;
         case (state)
            S_IDLE: begin
               collision <= multi_edge;
               if (any_edge) begin
                  tx_out      <= ch_in[win_idx];
                  owner       <= win_idx;
                  owner_valid <= 1'b1;
                  lock_cnt    <= CNT_RELOAD;
                  state       <= S_LOCKED;
               end
            end
            default: begin
               collision <= |other_edges;
               // Losing the enable forces the line idle immediately, whatever the timer says.
               if (!ch_en[owner]) begin
                  tx_out      <= 1'b1;
                  owner_valid <= 1'b0;
                  state       <= S_IDLE;
               end else if (ch_edge[owner]) begin
                  tx_out   <= ch_in[owner];
                  lock_cnt <= CNT_RELOAD;
               end else if (lock_cnt != '0) begin
                  lock_cnt <= lock_cnt - CNT_W'(1);
               end else if (tx_out) begin
                  owner_valid <= 1'b0;
                  state       <= S_IDLE;
               end
            end
         endcase
      end
   end
`else
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         prev_p0     <= '1;
         tx_out      <= 1'b1;
         owner       <= '0;
         owner_valid <= 1'b0;
         collision   <= 1'b0;
      end else begin
         prev_p0   <= ch_in;
         collision <= multi_edge;
         if (any_edge) begin
            tx_out      <= ch_in[win_idx];
            owner       <= win_idx;
            owner_valid <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_serial_out_arbiter.sv
// Directed vector bench for serial_out_arbiter (CHANNELS=3, LOCK_CYCLES=4); follows SOUT_LOCK_EN.
module tb_serial_out_arbiter;

   logic       clk_sys = 1'b0;
   logic       reset   = 1'b1;
   logic [2:0] ch_in   = 3'b111;
   logic [2:0] ch_en   = 3'b111;
   logic       tx_out;
   logic [1:0] owner;
   logic       owner_valid;
   logic       collision;

   int checks = 0;
   int passed = 0;

   always #5 clk_sys = ~clk_sys;

   serial_out_arbiter #(.CHANNELS(3), .LOCK_CYCLES(4)) dut (
      .clk_sys     (clk_sys),
      .reset       (reset),
      .ch_in       (ch_in),
      .ch_en       (ch_en),
      .tx_out      (tx_out),
      .owner       (owner),
      .owner_valid (owner_valid),
      .collision   (collision)
   );

   typedef struct {
      logic       rst;
      logic [2:0] cin;
      logic [2:0] cen;
      logic       tx;
      logic [1:0] own;
      logic       vld;
      logic       col;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, input logic [2:0] cin, input logic [2:0] cen,
                      input logic tx, input logic [1:0] own, input logic vld, input logic col);
      vec_t v;
      v.rst = rst; v.cin = cin; v.cen = cen;
      v.tx = tx; v.own = own; v.vld = vld; v.col = col;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   initial begin
      int n;
      // Both builds share reset and the all-idle stretch.
      add(1, 3'b111, 3'b111, 1, 0, 0, 0);
      add(1, 3'b111, 3'b111, 1, 0, 0, 0);
      for (int i = 0; i < 10; i++) add(0, 3'b111, 3'b111, 1, 0, 0, 0);
`ifdef SOUT_LOCK_EN
      add(0, 3'b101, 3'b111, 0, 1, 1, 0);   // ch1 falls, takes the line
      add(0, 3'b101, 3'b111, 0, 1, 1, 0);
      add(0, 3'b101, 3'b111, 0, 1, 1, 0);
      add(0, 3'b111, 3'b111, 1, 1, 1, 0);   // owner edge reloads timer
      add(0, 3'b111, 3'b111, 1, 1, 1, 0);
      add(0, 3'b111, 3'b111, 1, 1, 1, 0);
      add(0, 3'b111, 3'b111, 1, 1, 1, 0);
      add(0, 3'b111, 3'b111, 1, 1, 0, 0);   // timer expired, owner retained
      add(0, 3'b111, 3'b111, 1, 1, 0, 0);
      add(0, 3'b010, 3'b111, 0, 0, 1, 1);   // ch0 and ch2 coincide
      add(0, 3'b010, 3'b111, 0, 0, 1, 0);
      add(0, 3'b110, 3'b111, 0, 0, 1, 1);   // ch2 edge dropped while locked
      add(0, 3'b110, 3'b111, 0, 0, 1, 0);
      add(0, 3'b110, 3'b111, 0, 0, 1, 0);   // timer zero but tx low: hold
      add(0, 3'b111, 3'b111, 1, 0, 1, 0);
      add(0, 3'b111, 3'b111, 1, 0, 1, 0);
      add(0, 3'b111, 3'b111, 1, 0, 1, 0);
      add(0, 3'b111, 3'b111, 1, 0, 1, 0);
      add(0, 3'b111, 3'b111, 1, 0, 0, 0);
      add(0, 3'b011, 3'b111, 0, 2, 1, 0);   // ch2 owns low
      add(0, 3'b001, 3'b011, 1, 2, 0, 1);   // enable drop + same-cycle ch1 edge
      add(0, 3'b001, 3'b011, 1, 2, 0, 0);
      add(0, 3'b000, 3'b011, 0, 0, 1, 0);   // ch0 edge two cycles later
      add(0, 3'b101, 3'b111, 1, 0, 1, 1);
      add(0, 3'b101, 3'b111, 1, 0, 1, 0);
      add(0, 3'b101, 3'b111, 1, 0, 1, 0);
      add(0, 3'b101, 3'b111, 1, 0, 1, 0);
      add(0, 3'b101, 3'b111, 1, 0, 0, 0);
      add(0, 3'b111, 3'b111, 1, 1, 1, 0);
      add(0, 3'b101, 3'b111, 0, 1, 1, 0);   // ch1 owns with tx low
      add(1, 3'b101, 3'b111, 1, 0, 0, 0);   // reset mid-frame
      add(1, 3'b101, 3'b111, 1, 0, 0, 0);
      add(0, 3'b101, 3'b111, 0, 1, 1, 0);   // low bit at release is an edge
      for (int i = 0; i < 5; i++) add(0, 3'b101, 3'b111, 0, 1, 1, 0);
`else
      add(0, 3'b110, 3'b111, 0, 0, 1, 0);   // ch0 falls
      add(0, 3'b100, 3'b111, 0, 1, 1, 0);   // ch1 falls next cycle, takes over
      add(0, 3'b100, 3'b111, 0, 1, 1, 0);
      add(0, 3'b011, 3'b111, 1, 0, 1, 1);   // three coincident edges
      add(0, 3'b011, 3'b111, 1, 0, 1, 0);
      add(0, 3'b111, 3'b111, 1, 2, 1, 0);
      add(0, 3'b110, 3'b110, 1, 2, 1, 0);   // disabled channel ignored
      add(0, 3'b100, 3'b110, 0, 1, 1, 0);
      add(1, 3'b100, 3'b111, 1, 0, 0, 0);
      add(0, 3'b100, 3'b111, 0, 0, 1, 1);   // low bits at release are edges
      add(0, 3'b100, 3'b111, 0, 0, 1, 0);
`endif

      for (int i = 0; i < vecs.size(); i++) begin
         reset = vecs[i].rst;
         ch_in = vecs[i].cin;
         ch_en = vecs[i].cen;
         @(posedge clk_sys);
         #1;
         check($sformatf("v%0d tx_out", i), 32'(tx_out), 32'(vecs[i].tx));
         check($sformatf("v%0d owner", i), 32'(owner), 32'(vecs[i].own));
         check($sformatf("v%0d owner_valid", i), 32'(owner_valid), 32'(vecs[i].vld));
         check($sformatf("v%0d collision", i), 32'(collision), 32'(vecs[i].col));
      end

`ifdef SOUT_LOCK_EN
      // Release ch1 and measure the hold time until ownership lapses.
      ch_in = 3'b111;
      @(posedge clk_sys);
      #1;
      check("release tx_out", 32'(tx_out), 32'd1);
      check("release owner_valid", 32'(owner_valid), 32'd1);
      n = 0;
      while (owner_valid && n < 20) begin
         @(posedge clk_sys);
         #1;
         n++;
      end
      check("hold cycles", 32'(n), 32'd4);
      check("after hold owner", 32'(owner), 32'd1);
`else
      // owner_valid never drops without reset.
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk_sys);
         #1;
         if (owner_valid === 1'b1) n++;
      end
      check("idle owner_valid cycles", 32'(n), 32'd100);
      check("idle tx_out", 32'(tx_out), 32'd0);
`endif

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
